board_redraw_sequencer: RTL and testbench
=========================================

# board_redraw_sequencer

Walks every cell of one 10x10 battleship board and drives the per-cell drawing datapath (`update_cell_datapath`) directly upstream of it. For each cell it supplies the cell coordinates, the four game-piece bits for that cell and the cursor flag, and pulses START_DRAWING. It then holds the cell for the full 64-pixel draw window and raises the VGA plot strobe. When the whole board is finished it reports completion to the game controller.

## Interface
Parameters:
- BOARD_DIM, 10, cells per board row/column
- CELL_PIXELS, 64, pixels per cell (8x8)

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- REDRAW_REQ  in  1  one-cycle request to redraw the board
- board_side_in  in  1  board to draw, latched at request
- CURSOR_EN  in  1  cursor visible
- cursor_x, cursor_y  in  4 each  cursor cell
- player1_ship, player1_guess, player2_ship, player2_guess  in  100 each  board state, bit index = y*10+x
- board_x, board_y  out  4 each  current cell
- board_side  out  1  latched side
- player1_ship_piece, player1_guess_piece, player2_ship_piece, player2_guess_piece  out  1 each  bits for the current cell
- CURSOR  out  1  current cell is the cursor cell
- START_DRAWING  out  1  reset pulse to the cell datapath
- plot  out  1  VGA write enable
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- Reset value of every output is 0. FSM resets to IDLE; counters and the pending flag clear.
- States:
  - IDLE: waits for REDRAW_REQ; on it, latches board_side_in, clears x/y, goes to LOAD.
  - LOAD: one cycle; registers the piece bits at index y*10+x and computes CURSOR = CURSOR_EN & (x==cursor_x) & (y==cursor_y). Goes to START.
  - START: one cycle with START_DRAWING=1. Clears the 7-bit pixel counter. Goes to DRAW.
  - DRAW: 65 cycles (pixel counter 0..64).
    - plot=0 when counter=0, plot=1 for 1..64, matching the datapath's one-cycle colour register.
    - At counter=64: if x<9, x+1 and go to LOAD; else if y<9, x=0, y+1 and go to LOAD; else go to FINISH.
  - FINISH: DONE=1 for one cycle, then IDLE. If pending is set, clear it and go straight to LOAD with x=y=0 and board_side re-latched.
- BUSY=1 in every state except IDLE.
- REDRAW_REQ while BUSY sets pending (one deep; further requests merge). A request in the same cycle as FINISH also sets pending.
- Cursor coordinates >= 10 never match, so CURSOR stays 0.
- board_x, board_y, piece bits and CURSOR are held stable from LOAD through the end of DRAW.
- Board-state inputs are sampled only in LOAD; changes during DRAW take effect on the next cell.
- Index arithmetic uses 7 bits: y*10+x, maximum 99.

## Timing
- REDRAW_REQ sampled at edge 0 gives LOAD in cycle 1, START_DRAWING in cycle 2, and first plot=1 in cycle 4.
- Per cell: 1 LOAD + 1 START + 65 DRAW = 67 cycles.
- Full board: 6700 cycles. DONE is high in cycle 6701 after the request edge. Back-to-back via pending adds 0 idle cycles.
- RESET asserted mid-sequence: all outputs drop to 0 asynchronously; pending is lost; the next REDRAW_REQ after release starts from (0,0).

## Structure
- Shared package `board_pkg`:
  - BOARD_DIM, CELL_PIXELS
  - FSM state typedef: IDLE, LOAD, START, DRAW, FINISH
  - cell-index width constant (7)
  - the same package is used by the game controller.
- One sub-module, `board_cell_counter`: x/y counter with clear, step, row wrap at BOARD_DIM-1 and a `last_cell` output.

## Test plan
- RESET, then REDRAW_REQ, side=0, all boards 0 -> 100 START_DRAWING pulses, 6400 plot cycles, DONE in cycle 6701, BUSY low after DONE.
- player2_ship bit 23 set, board_side_in=1 -> player2_ship_piece=1 only while board_x=3, board_y=2.
- CURSOR_EN=1, cursor=(9,9) -> CURSOR=1 only for the last cell. Cursor=(12,0) -> CURSOR never asserted.
- Second REDRAW_REQ at cycle 3000 -> DONE at 6701, LOAD at 6702 with x=y=0, second DONE at 13402.
- RESET pulse at cycle 500 -> outputs 0 immediately, FSM in IDLE, no DONE.
- Per cell: plot low on the first DRAW cycle, then exactly 64 consecutive high cycles; START_DRAWING is never high while plot=1.

Source files
------------

// File: rtl/board_pkg.sv
// Shared battleship board constants, FSM states and cell-index helper.
// Also used by the game controller.
package board_pkg;

  localparam int unsigned BOARD_DIM   = 10;
  localparam int unsigned CELL_PIXELS = 64;
  localparam int unsigned CELL_IDX_W  = 7;
  localparam int unsigned COORD_W     = 4;
  localparam int unsigned PIX_W       = 7;
  localparam int unsigned NUM_CELLS   = BOARD_DIM * BOARD_DIM;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DRAW,
    FINISH
  } board_state_e;

  // Row-major bit index of a cell: y*BOARD_DIM + x, never above 99.
  function automatic logic [CELL_IDX_W-1:0] cell_index(input logic [COORD_W-1:0] x,
                                                       input logic [COORD_W-1:0] y);
    return CELL_IDX_W'(y) * CELL_IDX_W'(BOARD_DIM) + CELL_IDX_W'(x);
  endfunction

endpackage

// File: rtl/board_cell_counter.sv
// Row-major x/y cell walker with clear, step and registered last-cell flag.
module board_cell_counter
  import board_pkg::*;
#(
  parameter int unsigned DIM = BOARD_DIM
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               step_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_cell_o
);

  localparam logic [COORD_W-1:0] MaxCoord = COORD_W'(DIM - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               last_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (step_i) begin
      if (x_q == MaxCoord) begin
        x_d = '0;
        if (y_q != MaxCoord) y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      last_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      last_q <= (x_d == MaxCoord) && (y_d == MaxCoord);
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign last_cell_o = last_q;

endmodule

// File: rtl/board_redraw_sequencer.sv
// Walks all cells of one board, feeding the per-cell draw datapath and
// strobing plot for each cell's 64-pixel window; pulses DONE at the end.
module board_redraw_sequencer #(
  parameter int unsigned BOARD_DIM   = board_pkg::BOARD_DIM,
  parameter int unsigned CELL_PIXELS = board_pkg::CELL_PIXELS
) (
  input  logic                             CLOCK,
  input  logic                             RESET,
  input  logic                             REDRAW_REQ,
  input  logic                             board_side_in,
  input  logic                             CURSOR_EN,
  input  logic [board_pkg::COORD_W-1:0]    cursor_x,
  input  logic [board_pkg::COORD_W-1:0]    cursor_y,
  input  logic [BOARD_DIM*BOARD_DIM-1:0]   player1_ship,
  input  logic [BOARD_DIM*BOARD_DIM-1:0]   player1_guess,
  input  logic [BOARD_DIM*BOARD_DIM-1:0]   player2_ship,
  input  logic [BOARD_DIM*BOARD_DIM-1:0]   player2_guess,
  output logic [board_pkg::COORD_W-1:0]    board_x,
  output logic [board_pkg::COORD_W-1:0]    board_y,
  output logic                             board_side,
  output logic                             player1_ship_piece,
  output logic                             player1_guess_piece,
  output logic                             player2_ship_piece,
  output logic                             player2_guess_piece,
  output logic                             CURSOR,
  output logic                             START_DRAWING,
  output logic                             plot,
  output logic                             BUSY,
  output logic                             DONE
);
  import board_pkg::*;

  localparam logic [PIX_W-1:0] PixLast = PIX_W'(CELL_PIXELS);

  board_state_e         state_q;
  logic                 pending_q;
  logic                 side_q;
  logic                 p1s_q, p1g_q, p2s_q, p2g_q;
  logic                 cursor_q;
  logic                 start_q;
  logic                 plot_q;
  logic                 busy_q;
  logic                 done_q;
  logic [PIX_W-1:0]     pix_q;

  logic                 restart;
  logic                 cnt_step;
  logic                 last_cell;
  logic [COORD_W-1:0]   cell_x;
  logic [COORD_W-1:0]   cell_y;
  logic [CELL_IDX_W-1:0] idx;

  always_comb begin
    restart  = ((state_q == IDLE) && REDRAW_REQ) ||
               ((state_q == FINISH) && (pending_q || REDRAW_REQ));
    cnt_step = (state_q == DRAW) && (pix_q == PixLast) && !last_cell;
    idx      = cell_index(cell_x, cell_y);
  end

  board_cell_counter #(
    .DIM (BOARD_DIM)
  ) u_cell_counter (
    .clk_i       (CLOCK),
    .rst_i       (RESET),
    .clr_i       (restart),
    .step_i      (cnt_step),
    .x_o         (cell_x),
    .y_o         (cell_y),
    .last_cell_o (last_cell)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      side_q    <= 1'b0;
      p1s_q     <= 1'b0;
      p1g_q     <= 1'b0;
      p2s_q     <= 1'b0;
      p2g_q     <= 1'b0;
      cursor_q  <= 1'b0;
      start_q   <= 1'b0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pix_q     <= '0;
    end else begin
      start_q <= 1'b0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
      // One-deep request queue while a sequence is running.
      if (REDRAW_REQ && (state_q != IDLE) && (state_q != FINISH)) pending_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (REDRAW_REQ) begin
            side_q  <= board_side_in;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          p1s_q    <= player1_ship[idx];
          p1g_q    <= player1_guess[idx];
          p2s_q    <= player2_ship[idx];
          p2g_q    <= player2_guess[idx];
          cursor_q <= CURSOR_EN && (cursor_x == cell_x) && (cursor_y == cell_y);
          start_q  <= 1'b1;
          state_q  <= START;
        end
        START: begin
          pix_q   <= '0;
          state_q <= DRAW;
        end
        DRAW: begin
          if (pix_q == PixLast) begin
            // Piece bits go quiet between cells so they never pair with a stale x/y.
            p1s_q    <= 1'b0;
            p1g_q    <= 1'b0;
            p2s_q    <= 1'b0;
            p2g_q    <= 1'b0;
            cursor_q <= 1'b0;
            if (last_cell) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              state_q <= LOAD;
            end
          end else begin
            pix_q  <= pix_q + PIX_W'(1);
            plot_q <= 1'b1;
          end
        end
        FINISH: begin
          if (pending_q || REDRAW_REQ) begin
            pending_q <= 1'b0;
            side_q    <= board_side_in;
            state_q   <= LOAD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign board_x             = cell_x;
  assign board_y             = cell_y;
  assign board_side          = side_q;
  assign player1_ship_piece  = p1s_q;
  assign player1_guess_piece = p1g_q;
  assign player2_ship_piece  = p2s_q;
  assign player2_guess_piece = p2g_q;
  assign CURSOR              = cursor_q;
  assign START_DRAWING       = start_q;
  assign plot                = plot_q;
  assign BUSY                = busy_q;
  assign DONE                = done_q;

endmodule

// File: tb/tb_board_redraw_sequencer.sv
// Randomized bench for board_redraw_sequencer against a cycle-arithmetic model
// of the board walk (67 cycles per cell, 100 cells, FINISH, optional rerun).
module tb_board_redraw_sequencer;

  localparam int CPC     = 67;
  localparam int BOARD_T = 6700;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        REDRAW_REQ = 1'b0;
  logic        board_side_in = 1'b0;
  logic        CURSOR_EN = 1'b0;
  logic [3:0]  cursor_x = 4'd0;
  logic [3:0]  cursor_y = 4'd0;
  logic [99:0] player1_ship = '0;
  logic [99:0] player1_guess = '0;
  logic [99:0] player2_ship = '0;
  logic [99:0] player2_guess = '0;
  logic [3:0]  board_x, board_y;
  logic        board_side;
  logic        player1_ship_piece, player1_guess_piece;
  logic        player2_ship_piece, player2_guess_piece;
  logic        CURSOR, START_DRAWING, plot, BUSY, DONE;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK = ~CLOCK;

  board_redraw_sequencer dut (
    .CLOCK               (CLOCK),
    .RESET               (RESET),
    .REDRAW_REQ          (REDRAW_REQ),
    .board_side_in       (board_side_in),
    .CURSOR_EN           (CURSOR_EN),
    .cursor_x            (cursor_x),
    .cursor_y            (cursor_y),
    .player1_ship        (player1_ship),
    .player1_guess       (player1_guess),
    .player2_ship        (player2_ship),
    .player2_guess       (player2_guess),
    .board_x             (board_x),
    .board_y             (board_y),
    .board_side          (board_side),
    .player1_ship_piece  (player1_ship_piece),
    .player1_guess_piece (player1_guess_piece),
    .player2_ship_piece  (player2_ship_piece),
    .player2_guess_piece (player2_guess_piece),
    .CURSOR              (CURSOR),
    .START_DRAWING       (START_DRAWING),
    .plot                (plot),
    .BUSY                (BUSY),
    .DONE                (DONE)
  );

  function automatic logic [99:0] rand_board();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[99:0];
  endfunction

  function automatic logic [17:0] all_outputs();
    return {board_x, board_y, board_side, player1_ship_piece, player1_guess_piece,
            player2_ship_piece, player2_guess_piece, CURSOR, START_DRAWING, plot, BUSY, DONE};
  endfunction

  // Issues a request and checks every cycle against the board-walk model.
  task automatic run_board(input logic side, input int second_req, input bit mutate,
                           output int n_start, output int n_plot, output int n_cursor,
                           output int done1, output int done2);
    int total;
    logic [99:0] s1s, s1g, s2s, s2g;
    logic s_en;
    logic [3:0] s_cx, s_cy;
    total = (second_req > 0) ? 2 * BOARD_T + 2 : BOARD_T + 2;
    n_start = 0; n_plot = 0; n_cursor = 0; done1 = 0; done2 = 0;
    s1s = '0; s1g = '0; s2s = '0; s2g = '0; s_en = 1'b0; s_cx = '0; s_cy = '0;
    @(negedge CLOCK);
    REDRAW_REQ = 1'b1;
    board_side_in = side;
    @(posedge CLOCK); #1;
    REDRAW_REQ = 1'b0;
    board_side_in = ~side;
    for (int t = 1; t <= total; t++) begin
      int u, k, p, ex, ey;
      bit in_cell, fin, start_e, plot_e;
      logic side_e;
      logic [4:0] pcs_e;
      if (t <= BOARD_T + 1) u = t;
      else if (second_req > 0) u = t - (BOARD_T + 1);
      else u = 0;
      in_cell = (u >= 1) && (u <= BOARD_T);
      fin = (u == BOARD_T + 1);
      k = in_cell ? (u - 1) / CPC : 0;
      p = in_cell ? (u - 1) % CPC : 0;
      ex = k % 10;
      ey = k / 10;
      start_e = in_cell && (p == 1);
      plot_e = in_cell && (p >= 3);
      side_e = (t <= BOARD_T + 1) ? side : ~side;

      checks++;
      if ({START_DRAWING, plot, BUSY, DONE} !== {start_e, plot_e, in_cell || fin, fin}) begin
        errors++;
        $display("FAIL ctrl t=%0d start/plot/busy/done got=%b exp=%b", t,
                 {START_DRAWING, plot, BUSY, DONE}, {start_e, plot_e, in_cell || fin, fin});
      end
      if (in_cell) begin
        checks++;
        if ({board_x, board_y, board_side} !== {4'(ex), 4'(ey), side_e}) begin
          errors++;
          $display("FAIL cell t=%0d x/y/side got=%0d/%0d/%b exp=%0d/%0d/%b", t,
                   board_x, board_y, board_side, ex, ey, side_e);
        end
        if (p == 0) pcs_e = '0;
        else pcs_e = {s1s[k], s1g[k], s2s[k], s2g[k],
                      s_en && (int'(s_cx) == ex) && (int'(s_cy) == ey)};
        checks++;
        if ({player1_ship_piece, player1_guess_piece, player2_ship_piece,
             player2_guess_piece, CURSOR} !== pcs_e) begin
          errors++;
          $display("FAIL pieces t=%0d cell=%0d got=%b exp=%b", t, k,
                   {player1_ship_piece, player1_guess_piece, player2_ship_piece,
                    player2_guess_piece, CURSOR}, pcs_e);
        end
      end
      n_start += int'(START_DRAWING);
      n_plot += int'(plot);
      n_cursor += int'(CURSOR);
      if (DONE === 1'b1) begin
        if (done1 == 0) done1 = t;
        else done2 = t;
      end

      @(negedge CLOCK);
      if (mutate && ($urandom_range(0, 9) == 0)) begin
        player1_ship = rand_board();
        player1_guess = rand_board();
        player2_ship = rand_board();
        player2_guess = rand_board();
      end
      // Board inputs seen during a LOAD cycle are the ones the cell must show.
      if (in_cell && (p == 0)) begin
        s1s = player1_ship; s1g = player1_guess; s2s = player2_ship; s2g = player2_guess;
        s_en = CURSOR_EN; s_cx = cursor_x; s_cy = cursor_y;
      end
      REDRAW_REQ = (t == second_req);
      @(posedge CLOCK); #1;
    end
    REDRAW_REQ = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++;
    if (all_outputs() !== 18'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", all_outputs());
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic test_full_zero();
    int ns, np, nc, d1, d2;
    player1_ship = '0; player1_guess = '0; player2_ship = '0; player2_guess = '0;
    CURSOR_EN = 1'b0;
    run_board(1'b0, 0, 1'b0, ns, np, nc, d1, d2);
    checks++;
    if (ns != 100) begin errors++; $display("FAIL start_count got=%0d exp=100", ns); end
    checks++;
    if (np != 6400) begin errors++; $display("FAIL plot_count got=%0d exp=6400", np); end
    checks++;
    if (d1 != 6701 || d2 != 0) begin
      errors++;
      $display("FAIL done_cycle got=%0d,%0d exp=6701,0", d1, d2);
    end
  endtask

  task automatic test_piece_bit23();
    int ns, np, nc, d1, d2;
    player1_ship = rand_board(); player1_guess = rand_board();
    player2_guess = rand_board();
    player2_ship = '0;
    player2_ship[23] = 1'b1;
    CURSOR_EN = 1'b1; cursor_x = 4'd12; cursor_y = 4'd0;
    run_board(1'b1, 0, 1'b0, ns, np, nc, d1, d2);
    checks++;
    if (nc != 0) begin errors++; $display("FAIL cursor_out_of_range got=%0d exp=0", nc); end
  endtask

  task automatic test_cursor_last();
    int ns, np, nc, d1, d2;
    player1_ship = rand_board(); player1_guess = rand_board();
    player2_ship = rand_board(); player2_guess = rand_board();
    CURSOR_EN = 1'b1; cursor_x = 4'd9; cursor_y = 4'd9;
    run_board(1'b0, 0, 1'b1, ns, np, nc, d1, d2);
    checks++;
    if (nc != 66) begin errors++; $display("FAIL cursor_last_count got=%0d exp=66", nc); end
  endtask

  task automatic test_back_to_back();
    int ns, np, nc, d1, d2;
    CURSOR_EN = 1'b0;
    player1_ship = rand_board(); player2_ship = rand_board();
    run_board(1'b0, 3000, 1'b0, ns, np, nc, d1, d2);
    checks++;
    if (d1 != 6701 || d2 != 13402) begin
      errors++;
      $display("FAIL back_to_back_done got=%0d,%0d exp=6701,13402", d1, d2);
    end
    checks++;
    if (ns != 200) begin errors++; $display("FAIL back_to_back_starts got=%0d exp=200", ns); end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge CLOCK);
    REDRAW_REQ = 1'b1;
    board_side_in = 1'b1;
    @(posedge CLOCK); #1;
    REDRAW_REQ = 1'b0;
    // Now in cycle 1; advance to cycle 500, queueing a second request at cycle 200.
    for (int t = 1; t < 500; t++) begin
      @(negedge CLOCK);
      REDRAW_REQ = (t == 200);
      @(posedge CLOCK); #1;
    end
    REDRAW_REQ = 1'b0;
    checks++;
    if ({board_x, plot, BUSY} !== {4'd7, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mid_sequence x/plot/busy got=%0d/%b/%b exp=7/1/1", board_x, plot, BUSY);
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    checks++;
    if (all_outputs() !== 18'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", all_outputs());
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    stray = 0;
    repeat (300) begin
      @(posedge CLOCK); #1;
      if (BUSY !== 1'b0 || DONE !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL pending_lost stray_cycles got=%0d exp=0", stray); end
    @(negedge CLOCK);
    REDRAW_REQ = 1'b1;
    board_side_in = 1'b0;
    @(posedge CLOCK); #1;
    REDRAW_REQ = 1'b0;
    checks++;
    if ({board_x, board_y, BUSY, START_DRAWING} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_load got=%0d/%0d/%b/%b exp=0/0/1/0", board_x, board_y, BUSY, START_DRAWING);
    end
    @(posedge CLOCK); #1;
    checks++;
    if ({board_x, board_y, START_DRAWING} !== {4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_start got=%0d/%0d/%b exp=0/0/1", board_x, board_y, START_DRAWING);
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_zero();
    test_piece_bit23();
    test_cursor_last();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
